// File: rtl/bist_loopback_ctrl.sv
// Loopback BIST controller: sends a pattern sequence to the transmitter and checks the looped-back data.
// It reports sticky error flags, a saturating mismatch count and the index of the first failing pattern.
module bist_loopback_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PATTERNS = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ERR_CNT_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [DATA_WIDTH-1:0] SEED = 8'h01,
  localparam int IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic                     ClK,
  input  logic                     Clear_n,
  input  logic                     BIST_Start,
  input  logic                     BIST_Abort,
  input  logic [1:0]               Mode,
  input  logic                     Stop_On_Fail,
  input  logic                     Data_Rdy,
  input  logic [DATA_WIDTH-1:0]    Rx_Data,
  output logic                     BIST_Mode,
  output logic [DATA_WIDTH-1:0]    Tx_Data,
  output logic                     Transmit_Start,
  output logic                     BIST_Busy,
  output logic                     BIST_Done,
  output logic [2:0]               BIST_Error,
  output logic [ERR_CNT_WIDTH-1:0] Err_Count,
  output logic [IDX_W-1:0]         Fail_Index
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PATTERNS - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] alt_even_f();
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [DATA_WIDTH-1:0] ALT_EVEN = alt_even_f();

  function automatic logic [DATA_WIDTH-1:0] first_pattern_f(input logic [1:0] m);
    logic [DATA_WIDTH-1:0] r;
    case (m)
      2'b00:   r = SEED;
      2'b01:   r = ONE;
      2'b10:   r = (SEED == '0) ? ONE : SEED;  // an all-zero LFSR would lock up
      2'b11:   r = ALT_EVEN;
      default: r = SEED;
    endcase
    return r;
  endfunction

  // Each pattern is derived from the previous one, so no per-index arithmetic is needed.
  function automatic logic [DATA_WIDTH-1:0] next_pattern_f(input logic [1:0] m,
                                                           input logic [DATA_WIDTH-1:0] cur);
    logic [DATA_WIDTH-1:0] r;
    case (m)
      2'b00:   r = cur + ONE;
      2'b01:   r = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1]};
      2'b10:   r = cur[0] ? ({1'b0, cur[DATA_WIDTH-1:1]} ^ LFSR_TAPS) : {1'b0, cur[DATA_WIDTH-1:1]};
      2'b11:   r = ~cur;
      default: r = cur;
    endcase
    return r;
  endfunction

  state_t                     state_r, next_state_s;
  logic [1:0]                 mode_r;
  logic                       sof_r;
  logic [IDX_W-1:0]           idx_r;
  logic [TO_W-1:0]            to_cnt_r;
  logic [DATA_WIDTH-1:0]      rx_r;
  logic [DATA_WIDTH-1:0]      tx_data_r;
  logic [2:0]                 err_r;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_r;
  logic [IDX_W-1:0]           fail_idx_r;
  logic                       busy_r, tx_start_r, done_r;
  logic                       abort_s, timeout_s, mismatch_s;
  logic                       busy_nxt_s, tx_start_nxt_s, done_nxt_s;

  assign abort_s    = BIST_Abort && (state_r == S_SEND || state_r == S_WAIT || state_r == S_CHECK);
  assign timeout_s  = (state_r == S_WAIT) && !Data_Rdy && (to_cnt_r == TO_LAST);
  assign mismatch_s = (rx_r != tx_data_r);

  // State register
  always_ff @(posedge ClK or negedge Clear_n) begin
    if (!Clear_n) state_r <= S_IDLE;
    else          state_r <= next_state_s;
  end

  // Next-state logic; abort outranks data arrival, timeout and the compare result
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (BIST_Start) next_state_s = S_SEND;
        else            next_state_s = S_IDLE;
      end
      S_SEND: begin
        if (abort_s) next_state_s = S_DONE;
        else         next_state_s = S_WAIT;
      end
      S_WAIT: begin
        if (abort_s)        next_state_s = S_DONE;
        else if (Data_Rdy)  next_state_s = S_CHECK;
        else if (timeout_s) next_state_s = S_DONE;
        else                next_state_s = S_WAIT;
      end
      S_CHECK: begin
        if (abort_s)                  next_state_s = S_DONE;
        else if (mismatch_s && sof_r) next_state_s = S_DONE;
        else if (idx_r == IDX_LAST)   next_state_s = S_DONE;
        else                          next_state_s = S_SEND;
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with the state
  always_comb begin
    busy_nxt_s     = (next_state_s == S_SEND) || (next_state_s == S_WAIT) || (next_state_s == S_CHECK);
    tx_start_nxt_s = (next_state_s == S_SEND);
    done_nxt_s     = (next_state_s == S_DONE);
  end

  // Registered control outputs
  always_ff @(posedge ClK or negedge Clear_n) begin
    if (!Clear_n) begin
      busy_r     <= 1'b0;
      tx_start_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      tx_start_r <= tx_start_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  // Datapath: run setup, timeout counting, capture, compare and pattern stepping
  always_ff @(posedge ClK or negedge Clear_n) begin
    if (!Clear_n) begin
      mode_r     <= 2'b00;
      sof_r      <= 1'b0;
      idx_r      <= '0;
      to_cnt_r   <= '0;
      rx_r       <= '0;
      tx_data_r  <= '0;
      err_r      <= 3'b000;
      err_cnt_r  <= '0;
      fail_idx_r <= '0;
    end else begin
      if (abort_s) err_r[2] <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (BIST_Start) begin
            mode_r     <= Mode;
            sof_r      <= Stop_On_Fail;
            idx_r      <= '0;
            err_r      <= 3'b000;
            err_cnt_r  <= '0;
            fail_idx_r <= '0;
            tx_data_r  <= first_pattern_f(Mode);
          end
        end
        S_SEND: to_cnt_r <= '0;
        S_WAIT: begin
          to_cnt_r <= to_cnt_r + TO_W'(1);
          if (Data_Rdy) rx_r <= Rx_Data;
          if (timeout_s && !abort_s) err_r[1] <= 1'b1;
        end
        S_CHECK: begin
          if (!abort_s) begin
            if (mismatch_s) begin
              err_r[0] <= 1'b1;
              if (err_cnt_r != CNT_MAX) err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1);
              if (!err_r[0]) fail_idx_r <= idx_r;
            end
            if (next_state_s == S_SEND) begin
              idx_r     <= idx_r + IDX_W'(1);
              tx_data_r <= next_pattern_f(mode_r, tx_data_r);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign BIST_Mode      = busy_r;
  assign BIST_Busy      = busy_r;
  assign Transmit_Start = tx_start_r;
  assign BIST_Done      = done_r;
  assign Tx_Data        = tx_data_r;
  assign BIST_Error     = err_r;
  assign Err_Count      = err_cnt_r;
  assign Fail_Index     = fail_idx_r;

endmodule

// File: tb/tb_bist_loopback_ctrl.sv
// Scoreboard bench for bist_loopback_ctrl: a loopback responder echoes Tx_Data, a monitor checks
// every Transmit_Start and BIST_Done against expectations queued by the stimulus.
module tb_bist_loopback_ctrl;

  logic       ClK = 1'b0;
  logic       Clear_n = 1'b0;
  logic       BIST_Start = 1'b0;
  logic       BIST_Abort;
  logic [1:0] Mode = 2'b00;
  logic       Stop_On_Fail = 1'b0;
  logic       Data_Rdy;
  logic [7:0] Rx_Data;
  logic       BIST_Mode, Transmit_Start, BIST_Busy, BIST_Done;
  logic [7:0] Tx_Data;
  logic [2:0] BIST_Error;
  logic [3:0] Err_Count;
  logic [1:0] Fail_Index;

  bist_loopback_ctrl #(
    .DATA_WIDTH(8), .NUM_PATTERNS(4), .TIMEOUT_CYCLES(16), .ERR_CNT_WIDTH(4),
    .LFSR_TAPS(8'hB8), .SEED(8'h01)
  ) dut (
    .ClK(ClK), .Clear_n(Clear_n), .BIST_Start(BIST_Start), .BIST_Abort(BIST_Abort),
    .Mode(Mode), .Stop_On_Fail(Stop_On_Fail), .Data_Rdy(Data_Rdy), .Rx_Data(Rx_Data),
    .BIST_Mode(BIST_Mode), .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start),
    .BIST_Busy(BIST_Busy), .BIST_Done(BIST_Done), .BIST_Error(BIST_Error),
    .Err_Count(Err_Count), .Fail_Index(Fail_Index)
  );

  always #5 ClK = ~ClK;

  int cyc = 0;
  always @(posedge ClK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] err;
    logic [3:0] cnt;
    logic [1:0] fi;
    logic [7:0] tx;
    int         lat;
  } done_exp_t;

  logic [7:0] tx_q[$];
  done_exp_t  done_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // responder configuration, written by the stimulus before each run
  int         resp_limit = 4;
  int         abort_idx = -1;
  logic [3:0] corrupt_set = 4'b0000;
  logic [7:0] corrupt_val = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mode"}, BIST_Mode, 0);
    chk({tag, "_busy"}, BIST_Busy, 0);
    chk({tag, "_tx_start"}, Transmit_Start, 0);
    chk({tag, "_done"}, BIST_Done, 0);
    chk({tag, "_tx_data"}, Tx_Data, 0);
    chk({tag, "_error"}, BIST_Error, 0);
    chk({tag, "_err_count"}, Err_Count, 0);
    chk({tag, "_fail_index"}, Fail_Index, 0);
  endtask

  // Loopback responder: answers 3 cycles after each Transmit_Start, optionally corrupting or aborting
  initial begin
    int pnum;
    logic [7:0] d;
    Data_Rdy = 1'b0;
    BIST_Abort = 1'b0;
    Rx_Data = 8'h00;
    pnum = 0;
    forever begin
      @(negedge ClK);
      if (!BIST_Busy) pnum = 0;
      if (Transmit_Start) begin
        d = Tx_Data;
        if (pnum < resp_limit) begin
          repeat (3) @(negedge ClK);
          Data_Rdy = 1'b1;
          Rx_Data = (pnum < 4 && corrupt_set[pnum]) ? corrupt_val : d;
          BIST_Abort = (pnum == abort_idx);
          @(negedge ClK);
          Data_Rdy = 1'b0;
          BIST_Abort = 1'b0;
          Rx_Data = 8'h00;
        end
        pnum++;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transmit request or a done pulse
  initial begin
    int last_tx_cyc;
    done_exp_t e;
    last_tx_cyc = 0;
    forever begin
      @(negedge ClK);
      if (Clear_n) begin
        if (Transmit_Start) begin
          last_tx_cyc = cyc;
          chk("tx_expected", (tx_q.size() > 0), 1);
          if (tx_q.size() > 0) chk("tx_data", Tx_Data, tx_q.pop_front());
        end
        if (BIST_Done) begin
          chk("done_expected", (done_q.size() > 0), 1);
          if (done_q.size() > 0) begin
            e = done_q.pop_front();
            chk("done_error", BIST_Error, e.err);
            chk("done_err_count", Err_Count, e.cnt);
            chk("done_fail_index", Fail_Index, e.fi);
            chk("done_tx_data", Tx_Data, e.tx);
            chk("done_latency", cyc - last_tx_cyc, e.lat);
            chk("done_busy", BIST_Busy, 0);
          end
        end
      end
    end
  end

  task automatic do_run(input string name, input logic [1:0] m, input logic sof,
                        input int rl, input int ai, input logic [3:0] cs, input logic [7:0] cv,
                        input logic [7:0] etx [4], input int ntx,
                        input logic [2:0] eerr, input logic [3:0] ecnt, input logic [1:0] efi,
                        input int elat, input logic poke_start);
    done_exp_t e;
    logic seen;
    resp_limit = rl;
    abort_idx = ai;
    corrupt_set = cs;
    corrupt_val = cv;
    for (int i = 0; i < ntx; i++) tx_q.push_back(etx[i]);
    e.err = eerr; e.cnt = ecnt; e.fi = efi; e.tx = etx[ntx-1]; e.lat = elat;
    done_q.push_back(e);
    @(negedge ClK);
    Mode = m; Stop_On_Fail = sof; BIST_Start = 1'b1;
    @(negedge ClK);
    BIST_Start = 1'b0; Mode = ~m; Stop_On_Fail = ~sof;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge ClK);
      if (poke_start) BIST_Start = (k == 6);
      seen = BIST_Done;
    end
    BIST_Start = 1'b0;
    chk({name, "_done_seen"}, seen, 1);
    @(negedge ClK);
    chk({name, "_tx_drained"}, tx_q.size(), 0);
    chk({name, "_done_drained"}, done_q.size(), 0);
    chk({name, "_error_held"}, BIST_Error, eerr);
    chk({name, "_idle_busy"}, BIST_Busy, 0);
    tx_q.delete();
    done_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    #12;
    chk_zero("reset");
    @(negedge ClK);
    Clear_n = 1'b1;
    repeat (2) @(negedge ClK);

    do_run("count", 2'b00, 1'b0, 4, -1, 4'b0000, 8'h00, '{8'h01, 8'h02, 8'h03, 8'h04}, 4,
           3'b000, 4'd0, 2'd0, 5, 1'b1);
    do_run("walk", 2'b01, 1'b0, 4, -1, 4'b0100, 8'h00, '{8'h01, 8'h02, 8'h04, 8'h08}, 4,
           3'b001, 4'd1, 2'd2, 5, 1'b0);
    do_run("lfsr_sof", 2'b10, 1'b1, 4, -1, 4'b0010, 8'hFF, '{8'h01, 8'hB8, 8'h00, 8'h00}, 2,
           3'b001, 4'd1, 2'd1, 5, 1'b0);
    do_run("alt_timeout", 2'b11, 1'b0, 0, -1, 4'b0000, 8'h00, '{8'h55, 8'h00, 8'h00, 8'h00}, 1,
           3'b010, 4'd0, 2'd0, 17, 1'b0);
    do_run("abort", 2'b00, 1'b0, 4, 1, 4'b0010, 8'hFF, '{8'h01, 8'h02, 8'h00, 8'h00}, 2,
           3'b100, 4'd0, 2'd0, 4, 1'b0);
    do_run("lfsr_two_fail", 2'b10, 1'b0, 4, -1, 4'b1001, 8'h00, '{8'h01, 8'hB8, 8'h5C, 8'h2E}, 4,
           3'b001, 4'd2, 2'd0, 5, 1'b0);
    do_run("alt_full", 2'b11, 1'b0, 4, -1, 4'b0000, 8'h00, '{8'h55, 8'hAA, 8'h55, 8'hAA}, 4,
           3'b000, 4'd0, 2'd0, 5, 1'b0);

    // asynchronous reset while waiting for loopback data
    resp_limit = 4; abort_idx = -1; corrupt_set = 4'b0000;
    tx_q.push_back(8'h01);
    @(negedge ClK);
    Mode = 2'b00; Stop_On_Fail = 1'b0; BIST_Start = 1'b1;
    @(negedge ClK);
    BIST_Start = 1'b0;
    seen = Transmit_Start;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge ClK);
      seen = Transmit_Start;
    end
    chk("rst_tx_seen", seen, 1);
    repeat (2) @(negedge ClK);
    chk("rst_busy_before", BIST_Busy, 1);
    #2 Clear_n = 1'b0;
    #1 chk_zero("midrun_reset");
    tx_q.delete();
    done_q.delete();
    @(negedge ClK);
    Clear_n = 1'b1;
    repeat (10) @(negedge ClK);
    chk("post_reset_idle", BIST_Busy, 0);

    do_run("fresh", 2'b00, 1'b0, 4, -1, 4'b0000, 8'h00, '{8'h01, 8'h02, 8'h03, 8'h04}, 4,
           3'b000, 4'd0, 2'd0, 5, 1'b0);

    repeat (3) @(negedge ClK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
